// File: rtl/set_dispatcher.sv
// Job queue and sequencer for the SET engine: buffers host jobs, issues one at a time and
// holds each result for the host. Define SET_TIMEOUT_EN to add the engine watchdog.
module set_dispatcher #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        job_valid_i,
  output logic                        job_ready_o,
  input  logic [23:0]                 job_central_i,
  input  logic [11:0]                 job_radius_i,
  input  logic [1:0]                  job_mode_i,
  output logic [$clog2(FIFO_DEPTH):0] pending_o,
  output logic                        en_o,
  output logic [23:0]                 central_o,
  output logic [11:0]                 radius_o,
  output logic [1:0]                  mode_o,
  input  logic                        busy_i,
  input  logic                        valid_i,
  input  logic [7:0]                  candidate_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [7:0]                  res_candidate_o,
  output logic                        res_timeout_o,
  output logic [2:0]                  state_o
);

  // Handshakes: a transfer occurs on a rising clk_i edge where valid and ready are both 1;
  // valid never waits on ready, and ready may rise or fall independently of valid.
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int JW = 38;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESULT    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [JW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [JW-1:0]   job_q, job_d;
  logic            en_q, en_d;
  logic            res_valid_q, res_valid_d;
  logic [7:0]      res_cand_q, res_cand_d;
  logic            push, pop;

`ifdef SET_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`endif

  assign job_ready_o = (count_q < CW'(FIFO_DEPTH));

  always_comb begin
    push        = job_valid_i && job_ready_o;
    pop         = (state_q == IDLE) && (count_q != '0);
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    state_d     = state_q;
    job_d       = job_q;
    en_d        = 1'b0;
    res_valid_d = res_valid_q;
    res_cand_d  = res_cand_q;

    case (state_q)
      IDLE: begin
        if (pop) begin
          job_d   = mem_q[rd_ptr_q];
          en_d    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_BUSY;
      // Any valid_i here belongs to the previous job; only a busy_i rise moves us on.
      WAIT_BUSY: if (busy_i) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!busy_i && valid_i) begin
          res_cand_d  = candidate_i;
          res_valid_d = 1'b1;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SET_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (state_q == ISSUE) begin
      cnt_d = '0;
    end else if (state_q inside {WAIT_BUSY, WAIT_DONE}) begin
      cnt_d = cnt_q + 8'd1;
      if (state_d == RESULT) begin
        timeout_d = 1'b0;
      end else if (cnt_d == TIMEOUT_CNT) begin
        res_cand_d  = 8'hFF;
        res_valid_d = 1'b1;
        timeout_d   = 1'b1;
        state_d     = RESULT;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      job_q       <= '0;
      en_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_cand_q  <= '0;
`ifdef SET_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      job_q       <= job_d;
      en_q        <= en_d;
      res_valid_q <= res_valid_d;
      res_cand_q  <= res_cand_d;
`ifdef SET_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  // Queue storage carries no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {job_central_i, job_radius_i, job_mode_i};
  end

  assign pending_o       = count_q;
  assign en_o            = en_q;
  assign central_o       = job_q[37:14];
  assign radius_o        = job_q[13:2];
  assign mode_o          = job_q[1:0];
  assign res_valid_o     = res_valid_q;
  assign res_candidate_o = res_cand_q;
  assign state_o         = state_q;
`ifdef SET_TIMEOUT_EN
  assign res_timeout_o   = timeout_q;
`else
  assign res_timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_set_dispatcher.sv
// Directed bench for set_dispatcher: host-side job pushes, a scripted engine and result checks.
module tb_set_dispatcher;
  localparam int DEPTH = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WB = 3'd2, S_WD = 3'd3, S_RES = 3'd4;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        job_valid_i = 1'b0;
  logic        job_ready_o;
  logic [23:0] job_central_i = '0;
  logic [11:0] job_radius_i = '0;
  logic [1:0]  job_mode_i = '0;
  logic [2:0]  pending_o;
  logic        en_o;
  logic [23:0] central_o;
  logic [11:0] radius_o;
  logic [1:0]  mode_o;
  logic        busy_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [7:0]  candidate_i = '0;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic [7:0]  res_candidate_o;
  logic        res_timeout_o;
  logic [2:0]  state_o;

  logic [7:0]  exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk_i = ~clk_i;

  set_dispatcher #(.FIFO_DEPTH(DEPTH), .TIMEOUT(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_central_i(job_central_i), .job_radius_i(job_radius_i), .job_mode_i(job_mode_i),
    .pending_o(pending_o), .en_o(en_o),
    .central_o(central_o), .radius_o(radius_o), .mode_o(mode_o),
    .busy_i(busy_i), .valid_i(valid_i), .candidate_i(candidate_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_candidate_o(res_candidate_o), .res_timeout_o(res_timeout_o),
    .state_o(state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    job_valid_i   = 1'b1;
    job_central_i = c;
    job_radius_i  = r;
    job_mode_i    = m;
    check("push_ready", job_ready_o, 1);
    tick();
    job_valid_i = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    for (int i = 0; i < 200; i++) begin
      if (state_o == s) break;
      tick();
    end
    check(tag, state_o, s);
  endtask

  // Engine model from WAIT_BUSY: busy for busy_n cycles, then one valid cycle with cand.
  task automatic serve_job(input logic [7:0] cand, input int busy_n, input bit hold_valid);
    busy_i = 1'b1;
    tick();
    for (int i = 1; i < busy_n; i++) tick();
    busy_i      = 1'b0;
    valid_i     = 1'b1;
    candidate_i = cand;
    tick();
    if (!hold_valid) valid_i = 1'b0;
  endtask

  initial begin
    logic [7:0]  cand;
    logic [23:0] c;
    bit          en_seen, bad_valid, bad_cand, bad_state;
    int          k;

    // Reset state
    #2;
    check("rst_state", state_o, S_IDLE);
    check("rst_pending", pending_o, 0);
    check("rst_ready", job_ready_o, 1);
    check("rst_en", en_o, 0);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_res_cand", res_candidate_o, 0);
    check("rst_res_timeout", res_timeout_o, 0);
    check("rst_central", central_o, 0);
    repeat (2) tick();
    rst_n_i = 1'b1;
    tick();

    // Single job: accept at edge N, en_o seen by engine at edge N+2
    job_valid_i = 1'b1; job_central_i = 24'h334455; job_radius_i = 12'h234; job_mode_i = 2'd1;
    tick();
    job_valid_i = 1'b0;
    check("t1_pending_after_push", pending_o, 1);
    check("t1_en_low_n1", en_o, 0);
    tick();
    check("t1_en_high_n2", en_o, 1);
    check("t1_state_issue", state_o, S_ISSUE);
    check("t1_central", central_o, 24'h334455);
    check("t1_radius", radius_o, 12'h234);
    check("t1_mode", mode_o, 2'd1);
    check("t1_pending_popped", pending_o, 0);
    tick();
    check("t1_en_one_pulse", en_o, 0);
    check("t1_state_wait_busy", state_o, S_WB);
    busy_i  = 1'b1;
    en_seen = 1'b0;
    for (int i = 0; i < 18; i++) begin
      tick();
      en_seen |= en_o;
    end
    check("t1_state_wait_done", state_o, S_WD);
    check("t1_en_quiet_busy", en_seen, 0);
    check("t1_central_stable", central_o, 24'h334455);
    busy_i = 1'b0; valid_i = 1'b1; candidate_i = 8'd17;
    tick();
    valid_i = 1'b0;
    check("t1_res_valid", res_valid_o, 1);
    check("t1_res_cand", res_candidate_o, 8'd17);
    check("t1_res_timeout", res_timeout_o, 0);
    res_ready_i = 1'b1;
    tick();
    check("t1_res_consumed", res_valid_o, 0);
    check("t1_back_idle", state_o, S_IDLE);

    // Five back-to-back jobs, slow engine: queue fills, results in push order
    for (int i = 0; i < 5; i++) begin
      c = {16'hC0DE, 8'(8'h30 + i)};
      exp_q.push_back(c[7:0] ^ 8'h5A);
      push_job(c, 12'(12'h100 + i), 2'(i));
    end
    check("t2_pending_full", pending_o, 4);
    check("t2_ready_low", job_ready_o, 0);
    job_valid_i = 1'b1; job_central_i = 24'hBADBAD;
    repeat (3) tick();
    job_valid_i = 1'b0;
    check("t2_no_push_when_full", pending_o, 4);
    for (int i = 0; i < 5; i++) begin
      wait_state(S_WB, "t2_wait_issue");
      cand = central_o[7:0] ^ 8'h5A;
      serve_job(cand, 3 + i, 1'b0);
      check("t2_res_valid", res_valid_o, 1);
      check("t2_order", res_candidate_o, exp_q.pop_front());
    end
    tick();
    check("t2_drained", pending_o, 0);

    // Stale valid_i carried into the next WAIT_BUSY must be ignored
    push_job(24'h000011, 12'h111, 2'd0);
    push_job(24'h000022, 12'h222, 2'd1);
    wait_state(S_WB, "t3_wait_a");
    serve_job(8'h11, 2, 1'b1);
    check("t3_res_a", res_candidate_o, 8'h11);
    candidate_i = 8'h22;
    tick();
    wait_state(S_WB, "t3_wait_b");
    repeat (3) tick();
    check("t3_stale_state", state_o, S_WB);
    check("t3_stale_no_res", res_valid_o, 0);
    busy_i = 1'b1;
    repeat (2) tick();
    check("t3_busy_valid_state", state_o, S_WD);
    check("t3_busy_valid_no_res", res_valid_o, 0);
    busy_i = 1'b0; valid_i = 1'b1; candidate_i = 8'h33;
    tick();
    valid_i = 1'b0;
    check("t3_res_b", res_candidate_o, 8'h33);
    tick();
    res_ready_i = 1'b0;

    // Host stalls in RESULT for 10 cycles while the queue keeps accepting
    push_job(24'h000044, 12'h444, 2'd2);
    wait_state(S_WB, "t4_wait");
    serve_job(8'h44, 2, 1'b0);
    en_seen = 1'b0; bad_valid = 1'b0; bad_cand = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 2) begin
        job_valid_i   = 1'b1;
        job_central_i = (i == 0) ? 24'h000055 : 24'h000066;
      end
      tick();
      job_valid_i = 1'b0;
      en_seen   |= en_o;
      bad_valid |= !res_valid_o;
      bad_cand  |= (res_candidate_o != 8'h44);
    end
    check("t4_res_valid_held", bad_valid, 0);
    check("t4_res_cand_held", bad_cand, 0);
    check("t4_en_quiet", en_seen, 0);
    check("t4_queue_accepts", pending_o, 2);
    check("t4_state_result", state_o, S_RES);
    res_ready_i = 1'b1;
    tick();
    check("t4_released", res_valid_o, 0);
    wait_state(S_WB, "t4_wait_q0");
    serve_job(8'h55, 2, 1'b0);
    check("t4_res_q0", res_candidate_o, 8'h55);
    wait_state(S_WB, "t4_wait_q1");
    serve_job(8'h66, 2, 1'b0);
    check("t4_res_q1", res_candidate_o, 8'h66);
    tick();
    res_ready_i = 1'b0;

`ifdef SET_TIMEOUT_EN
    // Engine never answers: watchdog result after TIMEOUT cycles of waiting
    push_job(24'h000077, 12'h777, 2'd3);
    wait_state(S_WB, "t5_wait");
    k = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      k++;
      if (res_valid_o) break;
    end
    check("t5_timeout_cycles", k, 32);
    check("t5_timeout_cand", res_candidate_o, 8'hFF);
    check("t5_timeout_flag", res_timeout_o, 1);
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
`endif

    // Asynchronous reset in WAIT_DONE with two jobs queued
    push_job(24'h000088, 12'h888, 2'd0);
    push_job(24'h000099, 12'h999, 2'd1);
    push_job(24'h0000AA, 12'hAAA, 2'd2);
    wait_state(S_WB, "t6_wait");
    busy_i = 1'b1;
    tick();
    check("t6_in_wait_done", state_o, S_WD);
    check("t6_two_queued", pending_o, 2);
    #2 rst_n_i = 1'b0;
    #1;
    check("t6_rst_state", state_o, S_IDLE);
    check("t6_rst_pending", pending_o, 0);
    check("t6_rst_ready", job_ready_o, 1);
    check("t6_rst_en", en_o, 0);
    check("t6_rst_res_valid", res_valid_o, 0);
    check("t6_rst_res_cand", res_candidate_o, 0);
    check("t6_rst_central", central_o, 0);
    busy_i = 1'b0; valid_i = 1'b1; candidate_i = 8'hEE;
    tick();
    rst_n_i = 1'b1;
    valid_i = 1'b0;
    en_seen = 1'b0; bad_valid = 1'b0; bad_state = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      en_seen   |= en_o;
      bad_valid |= res_valid_o;
      bad_state |= (state_o != S_IDLE) || (pending_o != 0);
    end
    check("t6_no_result_after", bad_valid, 0);
    check("t6_no_issue_after", en_seen, 0);
    check("t6_stays_idle_empty", bad_state, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
